// File: rtl/rc4_pkg.sv
// Shared types and the character filter for the RC4 breaker datapath.
// The breaker's candidate checker and the message RAM writer both use is_valid_char.
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        INC,
        DONE
    } wr_state_t;

    // Plaintext candidates may only contain lowercase letters and spaces.
    function automatic logic is_valid_char(input byte_t c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

endpackage

// File: rtl/msg_ram_writer_if.sv
// Bundle between the breaker core / result RAM and the message writer.
// master = the writer itself; slave = the core and RAM side it talks to.
interface msg_ram_writer_if #(
    parameter int MSG_LEN = rc4_pkg::MSG_LEN_DEFAULT,
    parameter int ADDR_W  = 5
) ();
    import rc4_pkg::*;

    logic                    start;
    byte_t [MSG_LEN-1:0]     msg_data;
    logic  [ADDR_W-1:0]      ram_address;
    byte_t                   ram_data;
    logic                    ram_wren;
    logic                    busy;
    logic                    done;
    logic                    invalid;
    logic  [ADDR_W-1:0]      bad_index;

    modport master (
        input  start,
        input  msg_data,
        output ram_address,
        output ram_data,
        output ram_wren,
        output busy,
        output done,
        output invalid,
        output bad_index
    );

    modport slave (
        output start,
        output msg_data,
        input  ram_address,
        input  ram_data,
        input  ram_wren,
        input  busy,
        input  done,
        input  invalid,
        input  bad_index
    );

endinterface

// File: rtl/msg_ram_writer.sv
// Snapshots a MSG_LEN-byte message on start and writes it to RAM addresses 0..MSG_LEN-1, flagging non-[a-z ] bytes.
// Latency: 2 cycles per byte (done 2*MSG_LEN edges after start); no backpressure, the RAM accepts every strobe.
module msg_ram_writer
    import rc4_pkg::*;
#(
    parameter int MSG_LEN          = MSG_LEN_DEFAULT,
    parameter int ADDR_W           = 5,
    parameter bit ABORT_ON_INVALID = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    msg_ram_writer_if.master bus
);

    // One spare index bit so MSG_LEN == 2**ADDR_W cannot wrap.
    localparam int              IDX_W    = ADDR_W + 1;
    localparam int              SEL_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    wr_state_t           state_q, state_d;
    logic  [IDX_W-1:0]   idx_q, idx_d;
    logic                invalid_q, invalid_d;
    logic  [ADDR_W-1:0]  bad_q, bad_d;
    logic                load;
    byte_t [MSG_LEN-1:0] buf_q;
    byte_t               cur_byte;

    assign cur_byte = buf_q[idx_q[SEL_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            invalid_q <= 1'b0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            invalid_q <= invalid_d;
            bad_q     <= bad_d;
        end
    end

    // Snapshot so the core may move on to the next key while we write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= bus.msg_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        invalid_d = invalid_q;
        bad_d     = bad_q;
        load      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    idx_d     = '0;
                    invalid_d = 1'b0;
                    bad_d     = '0;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                if (!is_valid_char(cur_byte)) begin
                    if (!invalid_q) begin
                        invalid_d = 1'b1;
                        bad_d     = idx_q[ADDR_W-1:0];
                    end
                    // The offending byte is still strobed this cycle.
                    state_d = ABORT_ON_INVALID ? DONE : INC;
                end else begin
                    state_d = INC;
                end
            end

            INC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = WRITE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoded straight from state so an asserted reset kills the strobe at once.
    assign bus.ram_wren    = (state_q == WRITE);
    assign bus.busy        = (state_q == WRITE) || (state_q == INC);
    assign bus.done        = (state_q == DONE);
    assign bus.ram_address = idx_q[ADDR_W-1:0];
    assign bus.ram_data    = cur_byte;
    assign bus.invalid     = invalid_q;
    assign bus.bad_index   = bad_q;

endmodule

// File: doc/msg_ram_writer.md
Name: msg_ram_writer

Overview:
- Writes a 32-byte message held in a register array out to an on-chip RAM, one byte per write strobe.
- It is the write-side counterpart of the ROM-to-register message reader in the RC4 breaker datapath.
- The breaker core captures its decrypted candidate into this block on `start`. The block then writes the candidate to the result RAM at addresses 0..MSG_LEN-1.
- While writing, it checks that every byte is a lowercase letter or a space. With `ABORT_ON_INVALID` set, the first bad byte ends the transfer early so the key search can fail fast.

Parameters:
- MSG_LEN, 32, number of bytes transferred per run (array depth).
- ADDR_W, 5, RAM address width; MSG_LEN must not exceed 2**ADDR_W.
- ABORT_ON_INVALID, 1, 1 = stop writing after the first invalid byte; 0 = write all bytes and only flag the error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset).
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE or DONE.
- msg_data  input  8 x MSG_LEN  message bytes; index 0 is written to address 0.
- ram_address  output  ADDR_W  RAM write address.
- ram_data  output  8  RAM write data.
- ram_wren  output  1  RAM write enable, one cycle per byte.
- busy  output  1  high from the accepted start until DONE is entered.
- done  output  1  high while in DONE.
- invalid  output  1  sticky; set when a written byte fails the character check.
- bad_index  output  ADDR_W  index of the first invalid byte; valid only while invalid=1.

Behaviour:
- Reset (reset low, asynchronous) produces:
  - state = IDLE, index = 0;
  - ram_wren = 0, busy = 0, done = 0, invalid = 0, bad_index = 0;
  - ram_address = 0, ram_data = 0.
- ram_wren, busy and done decode combinationally from the state register. Reset therefore drops ram_wren in the same cycle it asserts; no partial write can follow a mid-transfer reset.
- States: IDLE, WRITE, INC, DONE.
- IDLE:
  - start = 1 at edge E0 snapshots all of msg_data into an internal buffer, sets index = 0, clears invalid and bad_index, and moves to WRITE.
  - msg_data changes after E0 have no effect on the current transfer.
- WRITE:
  - Drives ram_wren = 1, ram_address = index, ram_data = buf[index].
  - A byte is valid when it is 8'h20 or in the range 8'h61..8'h7A inclusive.
  - If the byte is invalid and invalid = 0: set invalid = 1 and bad_index = index at the closing edge.
  - If the byte is invalid and ABORT_ON_INVALID = 1: next state is DONE. The offending byte is still written.
  - Otherwise: next state is INC.
- INC:
  - ram_wren = 0.
  - If index == MSG_LEN-1, go to DONE and hold index.
  - Otherwise index <= index+1 and go to WRITE.
- DONE:
  - done = 1, busy = 0; outputs hold their values.
  - start = 1 restarts exactly as from IDLE, re-snapshotting msg_data and clearing invalid. done drops in the next cycle.
- Timing for a full run:
  - Byte i is strobed in the cycle after edge E(2i).
  - done rises at edge E(2·MSG_LEN): 64 cycles after start for MSG_LEN = 32.
  - busy is high for exactly 2·MSG_LEN cycles.
- Timing for an aborted run: an invalid byte k gives done at E(2k+1).
- start while busy (WRITE or INC) is ignored; no re-snapshot and no restart.
- Index arithmetic uses ADDR_W+1 bits internally so MSG_LEN = 2**ADDR_W cannot wrap. ram_address is the low ADDR_W bits.
- The RAM's write latency is not observed; one strobe per byte is sufficient.

Decomposition:
- Package rc4_pkg holds:
  - MSG_LEN_DEFAULT = 32;
  - byte_t (logic [7:0]);
  - the writer state enum {IDLE, WRITE, INC, DONE};
  - function is_valid_char(byte_t) returning 1 for 8'h20 or 8'h61..8'h7A. The breaker's own checker shares this function.
- No sub-module is needed; the block is one FSM plus a buffer.

Test Plan:
- Message "abcdefghijklmnopqrstuvwxyz abcde" with start pulsed once:
  - 32 ram_wren pulses, 2 cycles apart;
  - address 0..31 carries the matching bytes;
  - done high 64 cycles after start; invalid = 0.
- Byte 5 = 8'h41 with ABORT_ON_INVALID = 1:
  - 6 writes (addresses 0..5, address 5 carrying 8'h41);
  - done high at E11; invalid = 1, bad_index = 5; no write to address 6.
- Bytes 3 = 8'h7B and 9 = 8'h60 with ABORT_ON_INVALID = 0:
  - all 32 written; invalid = 1, bad_index = 3; done at E64.
- msg_data changed and start pulsed again at cycle 10 of a run:
  - both are ignored; written data equals the original snapshot;
  - a second start in DONE performs a new run with the new data and clears invalid.
- reset driven low asynchronously mid-cycle during the WRITE of byte 12:
  - ram_wren, busy and done go low immediately; bad_index and index return to 0;
  - after release, no writes occur until start.
- Boundary values 8'h20, 8'h61, 8'h7A → accepted; 8'h1F, 8'h60, 8'h7B → flagged.
